delay_commutator_top: RTL and testbench
=======================================

# delay_commutator_top

Reordering chain of cascaded radix-2 multi-path delay-commutator (MDC) stages for the streaming FFT datapath. Two complex samples enter per clock: the upper half of a frame on x0 and the lower half on x1. After log2(N)-1 commutator stages, the frame leaves as adjacent pairs (2k, 2k+1). The block is the reusable commutator backbone placed between FFT butterfly columns.

## Interface
Parameters:
- DATA_WIDTH, 32: width of each of the real and imaginary fields.
- N, 128: frame length; a power of two, at least 4.
- NUM_COMMUTATORS (localparam): log2(N)-1.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high.
- x0, input, complex_product_t: upper-path sample.
- x1, input, complex_product_t: lower-path sample.
- y0, output, complex_product_t: upper output sample.
- y1, output, complex_product_t: lower output sample.
- dc_chain_out_valid, output, 1: y0/y1 carry frame data.

## Operation
- Input is streamed with no gaps after reset. There is no input valid.
- Cycle 0 is the first rising edge with reset low; input pair (x0, x1) = (j, j+N/2) is presented in cycle j, for j = 0..N/2-1, and frames repeat back-to-back.
- Stage s (s = 0..NUM_COMMUTATORS-1) has delay D_s = (N/4) >> s. For N=128 the delays are 32, 16, 8, 4, 2, 1.
- Each stage has a counter of its valid input cycles. sel = bit log2(D_s) of that counter, so sel = 0 for the first D_s valid cycles, then toggles every D_s cycles.
- Within each stage, with d1 = x1 delayed D_s cycles:
  - sel=0: p0 = x0, p1 = d1.
  - sel=1: p0 = d1, p1 = x0.
  - Stage out0 = p0 delayed D_s cycles (registered); stage out1 = p1 (combinational mux).
- Stage valid rises D_s cycles after its input valid rises and stays high. Stage 0 input valid = not reset.
- Internal arrays: x0_dc[s], x1_dc[s] and dc_out_valid[s] hold the stage-s outputs. y0, y1 and dc_chain_out_valid are the last stage's outputs.
- Data is moved only, with no arithmetic; the r and i fields travel together, bit-exact.

## Timing
- Total latency L = sum of D_s = N/2-1 cycles (63 for N=128).
- In cycle L+k, for k = 0..N/2-1: y0 = sample 2k and y1 = sample 2k+1 of the frame.
- dc_chain_out_valid is 0 before cycle L and 1 from cycle L onward.
- Reset state:
  - All delay registers, counters and valid flags are cleared to 0.
  - y0, y1, x0_dc, x1_dc and all valid signals read 0 while reset is high.
- Reset asserted mid-stream: all state clears on that edge. The cycle after reset deasserts becomes a new cycle 0, and partial-frame contents are discarded.
- Counters wrap modulo 2*D_s. No other boundary exists because the stream is continuous.

## Structure
- Shared package (in verilog/headers.svh):
  - complex_product_t, a packed struct of signed [DATA_WIDTH-1:0] fields r and i.
  - Default DATA_WIDTH constant.
- One sub-module, delay_commutator, parameterised by DATA_WIDTH and DELAY, with ports clk, reset, x0, x1, in_valid, y0, y1, out_valid.
  - Contains two DELAY-deep shift registers, the counter and the mux.
- The top generates NUM_COMMUTATORS instances with DELAY = (N/4) >> s.

## Test plan
- N=8, x0.r = 0..3 and x1.r = 4..7:
  - x0_dc[0]/x1_dc[0] give (0,2), (1,3), (4,6), (5,7) in cycles 2-5.
  - y gives (0,1), (2,3), (4,5), (6,7) in cycles 3-6; valid rises in cycle 3.
- N=128, x0.r = i and x1.r = i+64 for i = 0..63, then 128 zero cycles:
  - y = (2k, 2k+1) in cycle 63+k.
  - Zeros from cycle 127.
  - dc_chain_out_valid = 0 through cycle 62 and 1 from cycle 63.
- N=128 with x.i = -x.r: imaginary fields follow the same permutation, sign preserved.
- Two back-to-back N=16 frames: the second frame emerges in natural pair order in cycles 15..22, with no gap.
- Reset pulsed at cycle 20 of an N=16 stream:
  - All outputs and valid flags are 0 the next cycle.
  - A fresh frame restarts with latency 7.
- N=4, a single stage with D=1: input (0,2), (1,3) gives y = (0,1), (2,3) in cycles 1-2.

Source files
------------

// File: rtl/delay_commutator_pkg.sv
// ============================================================================
// delay_commutator_pkg : complex sample type shared by the MDC commutator chain
// Revision: 1.0
// ============================================================================
`default_nettype none

package delay_commutator_pkg;

  localparam int CP_DATA_WIDTH = 32;

  typedef struct packed {
    logic signed [CP_DATA_WIDTH-1:0] r;
    logic signed [CP_DATA_WIDTH-1:0] i;
  } complex_product_t;

endpackage

`default_nettype wire

// File: rtl/delay_commutator.sv
// ============================================================================
// delay_commutator : one radix-2 MDC stage (two DELAY-deep lines plus a swap mux)
// Revision: 1.0
// ============================================================================
`default_nettype none

module delay_commutator
  import delay_commutator_pkg::*;
#(
  parameter int DATA_WIDTH = CP_DATA_WIDTH,
  parameter int DELAY      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  complex_product_t x0,
  input  complex_product_t x1,
  input  logic             in_valid,
  output complex_product_t y0,
  output complex_product_t y1,
  output logic             out_valid
);

  localparam int                 C_SEL_BIT  = $clog2(DELAY);
  localparam int                 C_CNT_W    = C_SEL_BIT + 1;
  localparam int                 C_WORD_W   = 2 * DATA_WIDTH;
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DELAY - 1);

  logic [C_WORD_W-1:0] r_x1_dly [DELAY];
  logic [C_WORD_W-1:0] r_p0_dly [DELAY];
  logic [C_CNT_W-1:0]  r_cnt;
  logic                r_out_valid;

  logic                w_sel;
  logic [C_WORD_W-1:0] w_x0;
  logic [C_WORD_W-1:0] w_d1;
  logic [C_WORD_W-1:0] w_p0;
  logic [C_WORD_W-1:0] w_p1;

  assign w_x0  = x0;
  assign w_d1  = r_x1_dly[DELAY-1];
  assign w_sel = r_cnt[C_SEL_BIT];
  assign w_p0  = w_sel ? w_d1 : w_x0;
  assign w_p1  = w_sel ? w_x0 : w_d1;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DELAY; k++) begin
        r_x1_dly[k] <= '0;
        r_p0_dly[k] <= '0;
      end
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_x1_dly[0] <= x1;
      r_p0_dly[0] <= w_p0;
      for (int k = 1; k < DELAY; k++) begin
        r_x1_dly[k] <= r_x1_dly[k-1];
        r_p0_dly[k] <= r_p0_dly[k-1];
      end
      if (in_valid) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Valid goes high after exactly DELAY valid inputs and then sticks.
      if (in_valid && (r_cnt == C_CNT_LAST)) begin
        r_out_valid <= 1'b1;
      end
    end
  end

  assign y0        = complex_product_t'(r_p0_dly[DELAY-1]);
  // The lower output is a combinational path, so force it quiet during reset.
  assign y1        = reset ? '0 : complex_product_t'(w_p1);
  assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: rtl/delay_commutator_top.sv
// ============================================================================
// delay_commutator_top : log2(N)-1 cascaded MDC stages turning half-frame
// streams into adjacent output pairs (2k, 2k+1).   Revision: 1.0
// ============================================================================
`default_nettype none

module delay_commutator_top
  import delay_commutator_pkg::*;
#(
  parameter int DATA_WIDTH = CP_DATA_WIDTH,
  parameter int N          = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  complex_product_t x0,
  input  complex_product_t x1,
  output complex_product_t y0,
  output complex_product_t y1,
  output logic             dc_chain_out_valid
);

  localparam int NUM_COMMUTATORS = $clog2(N) - 1;

  complex_product_t x0_dc        [NUM_COMMUTATORS];
  complex_product_t x1_dc        [NUM_COMMUTATORS];
  logic             dc_out_valid [NUM_COMMUTATORS];

  for (genvar s = 0; s < NUM_COMMUTATORS; s++) begin : g_stage
    complex_product_t w_in0;
    complex_product_t w_in1;
    logic             w_in_valid;

    if (s == 0) begin : g_first
      assign w_in0      = x0;
      assign w_in1      = x1;
      assign w_in_valid = ~reset;
    end else begin : g_chain
      assign w_in0      = x0_dc[s-1];
      assign w_in1      = x1_dc[s-1];
      assign w_in_valid = dc_out_valid[s-1];
    end

    delay_commutator #(
      .DATA_WIDTH (DATA_WIDTH),
      .DELAY      ((N / 4) >> s)
    ) u_dc (
      .clk       (clk),
      .reset     (reset),
      .x0        (w_in0),
      .x1        (w_in1),
      .in_valid  (w_in_valid),
      .y0        (x0_dc[s]),
      .y1        (x1_dc[s]),
      .out_valid (dc_out_valid[s])
    );
  end

  assign y0                 = x0_dc[NUM_COMMUTATORS-1];
  assign y1                 = x1_dc[NUM_COMMUTATORS-1];
  assign dc_chain_out_valid = dc_out_valid[NUM_COMMUTATORS-1];

endmodule

`default_nettype wire

// File: tb/tb_delay_commutator_top.sv
// ============================================================================
// tb_delay_commutator_top : scoreboard bench over N = 4, 8, 16 and 128 chains
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_delay_commutator_top;
  import delay_commutator_pkg::*;

  localparam int NI = 4;

  typedef struct packed {
    complex_product_t y0;
    complex_product_t y1;
  } pair_t;

  logic clk = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  function automatic int n_of(input int idx);
    case (idx)
      0:       return 4;
      1:       return 8;
      2:       return 16;
      default: return 128;
    endcase
  endfunction

  // Sample n of frame f: r counts up from base, i is its negation.
  function automatic complex_product_t samp(input int nn, input int base, input int f, input int n);
    complex_product_t s;
    int v;
    v = base + f * nn + n;
    s.r = v;
    s.i = -v;
    return s;
  endfunction

  task automatic check(input string name, input int nn, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s N=%0d actual=%h required=%h t=%0t", name, nn, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int NN  = n_of(g);
    localparam int H   = NN / 2;
    localparam int LAT = H - 1;

    logic             rst_g = 1'b1;
    complex_product_t x0_g = '0;
    complex_product_t x1_g = '0;
    complex_product_t y0_g;
    complex_product_t y1_g;
    logic             vld_g;

    pair_t sb[$];
    pair_t e;
    int    run = 0;
    logic  prev_rst = 1'b0;

    delay_commutator_top #(
      .DATA_WIDTH (32),
      .N          (NN)
    ) u_dut (
      .clk                (clk),
      .reset              (rst_g),
      .x0                 (x0_g),
      .x1                 (x1_g),
      .y0                 (y0_g),
      .y1                 (y1_g),
      .dc_chain_out_valid (vld_g)
    );

    // Streams whole frames followed by N-1 zero cycles so the trailing zero
    // frame fully emerges; abort_at raises reset at that stream cycle instead.
    task automatic stream(input int frames, input int base, input int abort_at);
      int    total_c;
      int    limit;
      int    f;
      int    j;
      pair_t p;
      total_c = frames * H + NN - 1;
      limit   = (abort_at >= 0 && abort_at < total_c) ? abort_at : total_c;
      for (int c = 0; c < limit; c++) begin
        if (c < frames * H) begin
          f = c / H;
          j = c % H;
          if (j == 0) begin
            for (int k = 0; k < H; k++) begin
              p.y0 = samp(NN, base, f, 2 * k);
              p.y1 = samp(NN, base, f, 2 * k + 1);
              sb.push_back(p);
            end
          end
          x0_g = samp(NN, base, f, j);
          x1_g = samp(NN, base, f, j + H);
        end else begin
          if (c == frames * H) begin
            p = '0;
            for (int k = 0; k < H; k++) sb.push_back(p);
          end
          x0_g = '0;
          x1_g = '0;
        end
        rst_g = 1'b0;
        @(posedge clk);
        #1;
      end
      rst_g = 1'b1;
      x0_g  = '0;
      x1_g  = '0;
      if (limit != total_c) begin
        sb.delete();
        @(posedge clk);
        #1;
      end else begin
        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", NN, 64'(sb.size()), 64'd0);
      end
    endtask

    initial begin
      rst_g = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      stream(2, 0, -1);
      stream(2, 1000, -1);
      stream(24 / H + 2, 500, 20);
      stream(1, 700, -1);
      done_cnt++;
    end

    always @(negedge clk) begin
      if (rst_g) begin
        if (prev_rst) begin
          check("rst_y0", NN, y0_g, 64'd0);
          check("rst_y1", NN, y1_g, 64'd0);
          check("rst_valid", NN, 64'(vld_g), 64'd0);
        end
        run = 0;
      end else begin
        check("valid", NN, 64'(vld_g), 64'(run >= LAT));
        if (vld_g) begin
          if (sb.size() == 0) begin
            check("sb_underflow", NN, 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            check("y0", NN, y0_g, e.y0);
            check("y1", NN, y1_g, e.y1);
          end
        end else begin
          check("idle_y0", NN, y0_g, 64'd0);
          check("idle_y1", NN, y1_g, 64'd0);
        end
        run++;
      end
      prev_rst = rst_g;
    end
  end

  initial begin
    for (int t = 0; t < 40000 && done_cnt < NI; t++) @(posedge clk);
    check("all_done", 0, 64'(done_cnt), 64'(NI));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
